axis_collector: RTL and testbench



---
 rtl/axis_collector.sv | 163 ++++++++++++++++
 tb/tb_axis_collector.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_collector.sv
// axis_collector: merges up to 16 AXI-Stream channels into one stream.
// Round-robin arbitration, with the grant held until the end of a packet.
// A one-deep output register slice feeds the merged stream.
// Define AXIS_COLLECTOR_WATCHDOG_EN to build the stall watchdog.
// The watchdog releases a stalled grant and raises a sticky timeout_err.
module axis_collector #(
  parameter int NUM_CH         = 16,
  parameter int DATA_W         = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        channel_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [3:0]               m_axis_tdest,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     timeout_err
);

  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axis_collector: parameter out of range");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state;
  logic [3:0]          grant_idx;
  logic [3:0]          ptr;
  logic [3:0]          next_ptr;
  logic                load_ok;
  logic                accept;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_CH-1:0]   req;
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic                req_found;
  logic [3:0]          req_idx;
  logic                wd_expire;

  // Channel index that is off positions above base, wrapped modulo NUM_CH.
  function automatic logic [3:0] wrap_idx(input logic [3:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return 4'(s);
  endfunction

  assign load_ok  = !m_axis_tvalid || m_axis_tready;
  assign accept   = (state == LOCKED) && sel_valid && load_ok;
  assign next_ptr = (grant_idx == 4'(NUM_CH - 1)) ? 4'd0 : grant_idx + 4'd1;
  assign req      = s_axis_tvalid & channel_enable;
  assign req_dbl  = {req, req};
  assign req_rot  = NUM_CH'(req_dbl >> ptr);

  // Route the granted channel's stream and give tready only to that channel.
  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == 4'(i)) begin
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        sel_data         = s_axis_tdata[i*DATA_W +: DATA_W];
        s_axis_tready[i] = (state == LOCKED) && load_ok;
      end
    end
  end

  // Round-robin pick: the first requester at or above ptr, wrapping to channel 0.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!req_found && req_rot[k]) begin
        req_found = 1'b1;
        req_idx   = wrap_idx(ptr, k);
      end
    end
  end

`ifdef AXIS_COLLECTOR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == LOCKED) && !accept &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Count the consecutive locked cycles in which no beat is accepted.
  always_ff @(posedge clk) begin
    if (rst || state != LOCKED || accept) wd_cnt <= '0;
    else                                  wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky error flag, set when the watchdog releases a stalled grant.
  always_ff @(posedge clk) begin
    if (rst)            timeout_err <= 1'b0;
    else if (wd_expire) timeout_err <= 1'b1;
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, hold the lock until tlast (or a watchdog release).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_found) begin
            grant_idx <= req_idx;
            state     <= LOCKED;
            busy      <= 1'b1;
          end
        end
        LOCKED: begin
          if ((accept && sel_last) || wd_expire) begin
            ptr   <= next_ptr;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-deep output slice: it loads only when empty or draining, so a stalled beat stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
    end else if (load_ok) begin
      m_axis_tvalid <= accept;
      if (accept) begin
        m_axis_tdata <= sel_data;
        m_axis_tlast <= sel_last;
        m_axis_tdest <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_axis_collector.sv
// tb_axis_collector: directed and randomized bench for axis_collector.
// A packet-level reference model predicts tready, the output slice and the ordering of beats.
module tb_axis_collector;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 256;
`ifdef AXIS_COLLECTOR_WATCHDOG_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  typedef struct { int ch; logic [DATA_W-1:0] data; logic last; } beat_t;
  typedef struct { logic [DATA_W-1:0] data; logic last; int dest; int cyc; } out_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        channel_enable = '1;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata = '0;
  logic [NUM_CH-1:0]        s_axis_tvalid = '0;
  logic [NUM_CH-1:0]        s_axis_tlast = '0;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic [3:0]               m_axis_tdest;
  logic                     m_axis_tready = 1'b1;
  logic                     busy;
  logic                     timeout_err;

  axis_collector #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .channel_enable(channel_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .m_axis_tready(m_axis_tready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;
  beat_t src_q[$];
  bit    vhold [NUM_CH];
  int    gap_pct = 0;
  int    rdy_mode = 0;
  int    pat_idx = 0;
  bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit    auto_fill = 1'b0;
  bit    m_locked = 1'b0;
  int    m_grant = 0;
  int    m_ptr = 0;
  int    m_wd = 0;
  bit    m_err = 1'b0;
  out_t  m_obuf[$];
  out_t  log_q[$];
  int    total_gen = 0;
  int    total_seen = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int find_front(input int c);
    for (int i = 0; i < src_q.size(); i++) if (src_q[i].ch == c) return i;
    return -1;
  endfunction

  task automatic push_packet(input int c, input int len, input bit rnd, input logic [DATA_W-1:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.ch   = c;
      b.data = rnd ? rand_word() : base + DATA_W'(i);
      b.last = (i == len - 1);
      src_q.push_back(b);
    end
  endtask

  task automatic applyStimulus();
    int idx;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      idx = find_front(c);
      if (idx >= 0 && (vhold[c] || $urandom_range(99) >= gap_pct)) begin
        s_axis_tvalid[c] = 1'b1;
        s_axis_tlast[c]  = src_q[idx].last;
        s_axis_tdata[c*DATA_W +: DATA_W] = src_q[idx].data;
      end
    end
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ($urandom_range(99) < 70);
      2: begin m_axis_tready = pat[pat_idx % 4]; pat_idx++; end
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  task automatic checkOutput();
    logic [NUM_CH-1:0] exp_rdy;
    bit                load_ok;
    out_t              o;
    if (rst) return;
    load_ok = (m_obuf.size() == 0) || m_axis_tready;
    exp_rdy = '0;
    if (m_locked) exp_rdy[m_grant] = load_ok;
    check("s_tready", DATA_W'(s_axis_tready), DATA_W'(exp_rdy));
    check("m_tvalid", DATA_W'(m_axis_tvalid), DATA_W'(m_obuf.size() != 0));
    check("busy", DATA_W'(busy), DATA_W'(m_locked));
    check("timeout_err", DATA_W'(timeout_err), DATA_W'(m_err));
    if (m_obuf.size() != 0) begin
      check("m_tdata", m_axis_tdata, m_obuf[0].data);
      check("m_tlast", DATA_W'(m_axis_tlast), DATA_W'(m_obuf[0].last));
      check("m_tdest", DATA_W'(m_axis_tdest), DATA_W'(m_obuf[0].dest));
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      o.data = m_axis_tdata; o.last = m_axis_tlast; o.dest = int'(m_axis_tdest); o.cyc = cycle;
      log_q.push_back(o);
      total_seen++;
    end
  endtask

  // Reference model: a packet-level round robin, using the distance of each requester above ptr.
  task automatic update_model();
    logic [NUM_CH-1:0] req;
    bit    load_ok, acc;
    int    best, bd, d, idx;
    beat_t b;
    out_t  o;
    if (rst) begin
      m_locked = 0; m_grant = 0; m_ptr = 0; m_wd = 0; m_err = 0;
      m_obuf.delete(); src_q.delete();
      for (int c = 0; c < NUM_CH; c++) vhold[c] = 1'b0;
      return;
    end
    load_ok = (m_obuf.size() == 0) || m_axis_tready;
    if (m_obuf.size() != 0 && m_axis_tready) void'(m_obuf.pop_front());
    acc = m_locked && s_axis_tvalid[m_grant] && load_ok;
    for (int c = 0; c < NUM_CH; c++)
      if (s_axis_tvalid[c] && !(acc && c == m_grant)) vhold[c] = 1'b1;
    if (m_locked) begin
      if (acc) begin
        idx = find_front(m_grant);
        b = src_q[idx];
        src_q.delete(idx);
        vhold[m_grant] = 1'b0;
        o.data = b.data; o.last = b.last; o.dest = m_grant; o.cyc = 0;
        m_obuf.push_back(o);
        m_wd = 0;
        if (b.last) begin m_locked = 0; m_ptr = (m_grant + 1) % NUM_CH; end
      end else begin
`ifdef AXIS_COLLECTOR_WATCHDOG_EN
        m_wd++;
        if (m_wd == TMO) begin
          m_locked = 0; m_ptr = (m_grant + 1) % NUM_CH; m_err = 1; m_wd = 0;
        end
`endif
      end
    end else begin
      req = s_axis_tvalid & channel_enable;
      bd = NUM_CH; best = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (req[c]) begin
          d = (c - m_ptr + NUM_CH) % NUM_CH;
          if (d < bd) begin bd = d; best = c; end
        end
      end
      if (bd < NUM_CH) begin m_locked = 1; m_grant = best; m_wd = 0; end
    end
  endtask

  task automatic step();
    int len;
    applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    update_model();
    if (auto_fill) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (find_front(c) < 0 && $urandom_range(99) < 8) begin
          len = $urandom_range(1, 4);
          push_packet(c, len, 1'b1, '0);
          total_gen += len;
        end
      end
    end
    cycle++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    rdy_mode = 0;
    gap_pct = 0;
    channel_enable = '1;
    log_q.delete();
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int b;
    b = budget;
    while (log_q.size() < n && b > 0) begin step(); b--; end
    check(name, DATA_W'(log_q.size()), DATA_W'(n));
  endtask

  task automatic expect_beat(input string name, input int i, input int dest, input logic [DATA_W-1:0] data, input bit last);
    if (i < log_q.size()) begin
      check({name, "_dest"}, DATA_W'(log_q[i].dest), DATA_W'(dest));
      check({name, "_data"}, log_q[i].data, data);
      check({name, "_last"}, DATA_W'(log_q[i].last), DATA_W'(last));
    end
  endtask

  initial begin
    int start;
    int seq01 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    // Reset, then stay idle.
    do_reset();
    repeat (20) step();
    check("idle_tvalid", DATA_W'(m_axis_tvalid), '0);
    check("idle_tready", DATA_W'(s_axis_tready), '0);
    check("idle_busy", DATA_W'(busy), '0);

    // A single 4-beat packet from channel 5, first beat two cycles after valid.
    push_packet(5, 4, 1'b0, DATA_W'(8'hA0));
    start = cycle;
    run_until("ch5_count", 4, 40);
    for (int i = 0; i < 4; i++) expect_beat("ch5", i, 5, DATA_W'(8'hA0 + i), i == 3);
    if (log_q.size() == 4) begin
      check("ch5_latency", DATA_W'(log_q[0].cyc - start), DATA_W'(2));
      check("ch5_rate", DATA_W'(log_q[3].cyc - log_q[0].cyc), DATA_W'(3));
    end

    // Contention between channels 2 and 9 with ptr at 0.
    do_reset();
    push_packet(2, 3, 1'b0, DATA_W'(8'h20));
    push_packet(9, 3, 1'b0, DATA_W'(8'h90));
    run_until("cont_count", 6, 60);
    for (int i = 0; i < 3; i++) expect_beat("cont2", i, 2, DATA_W'(8'h20 + i), i == 2);
    for (int i = 0; i < 3; i++) expect_beat("cont9", i + 3, 9, DATA_W'(8'h90 + i), i == 2);

    // Fairness: channels 0 and 1 both stream single-beat packets.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_packet(0, 1, 1'b0, DATA_W'(16'h0100 + i));
      push_packet(1, 1, 1'b0, DATA_W'(16'h1100 + i));
    end
    run_until("fair_count", 8, 80);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      check("fair_dest", DATA_W'(log_q[i].dest), DATA_W'(seq01[i]));

    // Backpressure on a 6-beat packet from channel 15, then a ptr wrap check.
    do_reset();
    rdy_mode = 2;
    pat_idx = 0;
    push_packet(15, 6, 1'b0, DATA_W'(8'hF0));
    run_until("bp_count", 6, 80);
    for (int i = 0; i < 6; i++) expect_beat("bp", i, 15, DATA_W'(8'hF0 + i), i == 5);
    rdy_mode = 0;
    log_q.delete();
    push_packet(15, 1, 1'b0, DATA_W'(8'h5F));
    push_packet(14, 1, 1'b0, DATA_W'(8'h4E));
    run_until("wrap_count", 2, 40);
    expect_beat("wrap_first", 0, 14, DATA_W'(8'h4E), 1'b1);
    expect_beat("wrap_second", 1, 15, DATA_W'(8'h5F), 1'b1);

    // Reset mid-packet while a beat is stalled in the output slice.
    do_reset();
    rdy_mode = 3;
    push_packet(7, 4, 1'b0, DATA_W'(8'h70));
    repeat (4) step();
    do_reset();
    repeat (5) step();
    check("rst_drop_beats", DATA_W'(log_q.size()), '0);
    check("rst_drop_tvalid", DATA_W'(m_axis_tvalid), '0);

`ifdef AXIS_COLLECTOR_WATCHDOG_EN
    // Watchdog: channel 3 stalls mid-packet, then channel 4 must still be served.
    do_reset();
    push_packet(3, 1, 1'b0, DATA_W'(8'h33));
    src_q[src_q.size() - 1].last = 1'b0;
    repeat (3 + TMO + 2) step();
    check("wd_err", DATA_W'(timeout_err), DATA_W'(1));
    check("wd_busy", DATA_W'(busy), '0);
    log_q.delete();
    push_packet(4, 2, 1'b0, DATA_W'(8'h40));
    run_until("wd_next_count", 2, 40);
    expect_beat("wd_next", 1, 4, DATA_W'(8'h41), 1'b1);
`endif

    // Randomized traffic with gaps, random backpressure and changing enables.
    do_reset();
    total_gen = 0;
    total_seen = 0;
    auto_fill = 1'b1;
    gap_pct = 30;
    rdy_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) channel_enable = NUM_CH'($urandom | $urandom);
      step();
    end
    auto_fill = 1'b0;
    gap_pct = 0;
    rdy_mode = 0;
    channel_enable = '1;
    begin
      int b;
      b = 2000;
      while ((src_q.size() > 0 || m_obuf.size() > 0) && b > 0) begin step(); b--; end
    end
    check("rand_drained", DATA_W'(src_q.size()), '0);
    check("rand_total", DATA_W'(total_seen), DATA_W'(total_gen));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
